// File: rtl/mc_control_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The sequencer side (master) reads the opcode and memory handshake and
// drives every datapath strobe and mux select. The datapath side (slave)
// is the mirror image.
interface mc_control_if;
   // Inputs to the sequencer
   logic [5:0]  opcode;
   logic        mem_ready;
   // PC update controls
   logic        PCWrite;
   logic        PCWriteCond;
   logic [1:0]  PCSource;
   // Memory / IR strobes
   logic        IorD;
   logic        MemRead;
   logic        MemWrite;
   logic        IRWrite;
   // Register file controls
   logic        RegWrite;
   logic        RegDst;
   logic        MemtoReg;
   // ALU controls
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUOp;
   // Status / debug
   logic [3:0]  state;
   logic        illegal_op;
   logic [31:0] instr_count;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, PCSource,
      output IorD, MemRead, MemWrite, IRWrite,
      output RegWrite, RegDst, MemtoReg,
      output ALUSrcA, ALUSrcB, ALUOp,
      output state, illegal_op, instr_count
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, PCSource,
      input  IorD, MemRead, MemWrite, IRWrite,
      input  RegWrite, RegDst, MemtoReg,
      input  ALUSrcA, ALUSrcB, ALUOp,
      input  state, illegal_op, instr_count
   );
endinterface

// File: rtl/mc_control.sv
// Multicycle control sequencer for the MIPS subset (lw, sw, R-type, addi,
// beq, j). The state and the completed-fetch counter are registered; every
// datapath control is decoded combinationally from the current state (and
// mem_ready while fetching), then gated to zero while reset is held low so
// that no write can leak out while the machine is being reset.
module mc_control (
   input  logic         clk,
   input  logic         rst,
   mc_control_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t      state_reg;
   logic [31:0] instr_count_reg;

   // Ungated decode of the current state
   logic        pc_write;
   logic        pc_write_cond;
   logic [1:0]  pc_source;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        reg_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        illegal;
   logic        opcode_known;

   // Opcodes that DECODE knows how to dispatch
   always_comb begin
      opcode_known = 1'b0;
      case (bus.opcode)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: opcode_known = 1'b1;
         default:                                       opcode_known = 1'b0;
      endcase
   end

   // State register and completed-fetch counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= S_FETCH;
         instr_count_reg <= '0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               // Hold here until memory returns the instruction word
               if (bus.mem_ready) begin
                  state_reg       <= S_DECODE;
                  instr_count_reg <= instr_count_reg + 32'd1;
               end
            end
            S_DECODE: begin
               case (bus.opcode)
                  OP_LW, OP_SW: state_reg <= S_MEMADR;
                  OP_RTYPE:     state_reg <= S_EXEC;
                  OP_BEQ:       state_reg <= S_BRANCH;
                  OP_J:         state_reg <= S_JUMP;
                  OP_ADDI:      state_reg <= S_ADDIEX;
                  default:      state_reg <= S_FETCH;
               endcase
            end
            S_MEMADR: begin
               if (bus.opcode == OP_SW) begin
                  state_reg <= S_MEMWR;
               end else begin
                  state_reg <= S_MEMRD;
               end
            end
            S_MEMRD: begin
               if (bus.mem_ready) begin
                  state_reg <= S_MEMWB;
               end
            end
            S_MEMWR: begin
               if (bus.mem_ready) begin
                  state_reg <= S_FETCH;
               end
            end
            S_EXEC:   state_reg <= S_RWB;
            S_ADDIEX: state_reg <= S_ADDIWB;
            S_MEMWB,
            S_RWB,
            S_BRANCH,
            S_JUMP,
            S_ADDIWB: state_reg <= S_FETCH;
            // Codes 12..15 are never entered on purpose; recover via FETCH
            default:  state_reg <= S_FETCH;
         endcase
      end
   end

   // Per-state control decode; anything not set stays 0
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      illegal       = 1'b0;
      case (state_reg)
         S_FETCH: begin
            // PC+4 is computed every fetch cycle but only committed (with
            // the IR load) in the cycle memory reports ready, so the PC
            // advances exactly once however long the fetch waits.
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = bus.mem_ready;
            pc_write  = bus.mem_ready;
         end
         S_DECODE: begin
            // Speculatively form the branch target into ALUOut
            alu_src_b = 2'b11;
            illegal   = ~opcode_known;
         end
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            // Compare A-B; PC takes the target held in ALUOut if zero
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Outputs: everything reads 0 while reset is held low
   assign bus.PCWrite     = rst & pc_write;
   assign bus.PCWriteCond = rst & pc_write_cond;
   assign bus.PCSource    = rst ? pc_source : 2'b00;
   assign bus.IorD        = rst & i_or_d;
   assign bus.MemRead     = rst & mem_read;
   assign bus.MemWrite    = rst & mem_write;
   assign bus.IRWrite     = rst & ir_write;
   assign bus.RegWrite    = rst & reg_write;
   assign bus.RegDst      = rst & reg_dst;
   assign bus.MemtoReg    = rst & mem_to_reg;
   assign bus.ALUSrcA     = rst & alu_src_a;
   assign bus.ALUSrcB     = rst ? alu_src_b : 2'b00;
   assign bus.ALUOp       = rst ? alu_op : 2'b00;
   assign bus.illegal_op  = rst & illegal;
   assign bus.state       = state_reg;
   assign bus.instr_count = instr_count_reg;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a cycle-by-cycle vector table with
// hand-computed state, control word and counter, plus hand-written
// sequences for reset, illegal opcode and counter wrap.
module tb_mc_control;

   logic clk = 1'b0;
   logic rst = 1'b0;

   mc_control_if bus ();

   mc_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Control word layout:
   // {PCWrite, PCWriteCond, PCSource[1:0], IorD, MemRead, MemWrite, IRWrite,
   //  RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], illegal_op}
   localparam logic [17:0] C_ZERO    = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [17:0] C_FETCH1  = 18'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
   localparam logic [17:0] C_FETCH0  = 18'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
   localparam logic [17:0] C_DEC     = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
   localparam logic [17:0] C_DEC_ILL = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_1;
   localparam logic [17:0] C_MEMADR  = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
   localparam logic [17:0] C_MEMRD   = 18'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
   localparam logic [17:0] C_MEMWB   = 18'b0_0_00_0_0_0_0_1_0_1_0_00_00_0;
   localparam logic [17:0] C_MEMWR   = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
   localparam logic [17:0] C_EXEC    = 18'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
   localparam logic [17:0] C_RWB     = 18'b0_0_00_0_0_0_0_1_1_0_0_00_00_0;
   localparam logic [17:0] C_BRANCH  = 18'b0_1_01_0_0_0_0_0_0_0_1_00_01_0;
   localparam logic [17:0] C_JUMP    = 18'b1_0_10_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [17:0] C_ADDIEX  = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
   localparam logic [17:0] C_ADDIWB  = 18'b0_0_00_0_0_0_0_1_0_0_0_00_00_0;

   localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_R = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_BEQ = 6'h04, OP_J = 6'h02;
   localparam logic [5:0] OP_BAD = 6'h3F;

   typedef struct {
      logic [5:0]  opcode;
      logic        mem_ready;
      logic [3:0]  exp_state;
      logic [17:0] exp_ctl;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [17:0] get_ctl();
      return {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD,
              bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite,
              bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
              bus.ALUOp, bus.illegal_op};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic [17:0] ctl, input logic [31:0] cnt);
      vec_t v;
      v.opcode = op; v.mem_ready = rdy; v.exp_state = st; v.exp_ctl = ctl; v.exp_cnt = cnt;
      vecs.push_back(v);
   endtask

   initial begin
      // ---------------- vector table (one row per clock cycle) ----------------
      // Zero-wait lw, sw, R-type, addi, beq, j
      add(OP_LW, 1, 0, C_FETCH1, 0);  add(OP_LW, 1, 1, C_DEC, 1);
      add(OP_LW, 1, 2, C_MEMADR, 1);  add(OP_LW, 1, 3, C_MEMRD, 1);
      add(OP_LW, 1, 4, C_MEMWB, 1);
      add(OP_SW, 1, 0, C_FETCH1, 1);  add(OP_SW, 1, 1, C_DEC, 2);
      add(OP_SW, 1, 2, C_MEMADR, 2);  add(OP_SW, 1, 5, C_MEMWR, 2);
      add(OP_R, 1, 0, C_FETCH1, 2);   add(OP_R, 1, 1, C_DEC, 3);
      add(OP_R, 1, 6, C_EXEC, 3);     add(OP_R, 1, 7, C_RWB, 3);
      add(OP_ADDI, 1, 0, C_FETCH1, 3); add(OP_ADDI, 1, 1, C_DEC, 4);
      add(OP_ADDI, 1, 10, C_ADDIEX, 4); add(OP_ADDI, 1, 11, C_ADDIWB, 4);
      add(OP_BEQ, 1, 0, C_FETCH1, 4); add(OP_BEQ, 1, 1, C_DEC, 5);
      add(OP_BEQ, 1, 8, C_BRANCH, 5);
      add(OP_J, 1, 0, C_FETCH1, 5);   add(OP_J, 1, 1, C_DEC, 6);
      add(OP_J, 1, 9, C_JUMP, 6);
      // Fetch wait of 3 cycles; mem_ready low elsewhere must be ignored
      add(OP_R, 0, 0, C_FETCH0, 6);   add(OP_R, 0, 0, C_FETCH0, 6);
      add(OP_R, 0, 0, C_FETCH0, 6);   add(OP_R, 1, 0, C_FETCH1, 6);
      add(OP_R, 0, 1, C_DEC, 7);      add(OP_R, 0, 6, C_EXEC, 7);
      add(OP_R, 0, 7, C_RWB, 7);
      // lw with a 2-cycle MEMRD wait
      add(OP_LW, 1, 0, C_FETCH1, 7);  add(OP_LW, 0, 1, C_DEC, 8);
      add(OP_LW, 0, 2, C_MEMADR, 8);  add(OP_LW, 0, 3, C_MEMRD, 8);
      add(OP_LW, 0, 3, C_MEMRD, 8);   add(OP_LW, 1, 3, C_MEMRD, 8);
      add(OP_LW, 0, 4, C_MEMWB, 8);
      // sw with a 1-cycle MEMWR wait
      add(OP_SW, 1, 0, C_FETCH1, 8);  add(OP_SW, 1, 1, C_DEC, 9);
      add(OP_SW, 1, 2, C_MEMADR, 9);  add(OP_SW, 0, 5, C_MEMWR, 9);
      add(OP_SW, 1, 5, C_MEMWR, 9);

      // ---------------- reset ----------------
      bus.opcode = OP_R;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset_state", 32'(bus.state), 32'd0);
      check("reset_count", bus.instr_count, 32'd0);
      check("reset_ctl", 32'(get_ctl()), 32'(C_ZERO));
      @(negedge clk);
      rst = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         bus.opcode = vecs[i].opcode;
         bus.mem_ready = vecs[i].mem_ready;
         #1;
         $display("vec %0d op=%02h rdy=%0d state=%0d ctl=%05h cnt=%0d", i,
                  vecs[i].opcode, vecs[i].mem_ready, bus.state, get_ctl(), bus.instr_count);
         check($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].exp_state));
         check($sformatf("vec%0d_ctl", i), 32'(get_ctl()), 32'(vecs[i].exp_ctl));
         check($sformatf("vec%0d_count", i), bus.instr_count, vecs[i].exp_cnt);
         @(negedge clk);
      end
      #1;
      check("after_table_state", 32'(bus.state), 32'd0);
      check("after_table_count", bus.instr_count, 32'd9);

      // ---------------- illegal opcode ----------------
      bus.opcode = OP_BAD;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      #1;
      $display("illegal decode: state=%0d ctl=%05h", bus.state, get_ctl());
      check("illegal_dec_state", 32'(bus.state), 32'd1);
      check("illegal_dec_ctl", 32'(get_ctl()), 32'(C_DEC_ILL));
      @(negedge clk);
      #1;
      $display("illegal after: state=%0d ctl=%05h", bus.state, get_ctl());
      check("illegal_next_state", 32'(bus.state), 32'd0);
      check("illegal_next_ctl", 32'(get_ctl()), 32'(C_FETCH1));
      check("illegal_count", bus.instr_count, 32'd10);

      // ---------------- counter wrap ----------------
      bus.opcode = OP_R;
      force dut.instr_count_reg = 32'hFFFF_FFFF;
      #1;
      release dut.instr_count_reg;
      #1;
      check("wrap_preload", bus.instr_count, 32'hFFFF_FFFF);
      @(negedge clk);
      #1;
      $display("wrap: state=%0d cnt=%08h", bus.state, bus.instr_count);
      check("wrap_count", bus.instr_count, 32'h0000_0000);
      check("wrap_state", 32'(bus.state), 32'd1);

      // ---------------- reset from mid-EXEC ----------------
      @(negedge clk);
      #1;
      check("pre_reset_exec_state", 32'(bus.state), 32'd6);
      rst = 1'b0;
      #1;
      check("reset_exec_gated_ctl", 32'(get_ctl()), 32'(C_ZERO));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         $display("reset cycle %0d: state=%0d ctl=%05h cnt=%0d", k, bus.state, get_ctl(), bus.instr_count);
         check($sformatf("reset_hold%0d_state", k), 32'(bus.state), 32'd0);
         check($sformatf("reset_hold%0d_ctl", k), 32'(get_ctl()), 32'(C_ZERO));
         check($sformatf("reset_hold%0d_count", k), bus.instr_count, 32'd0);
      end
      rst = 1'b1;
      #1;
      check("release_memread", 32'(bus.MemRead), 32'd1);
      check("release_ctl", 32'(get_ctl()), 32'(C_FETCH1));
      @(negedge clk);
      #1;
      check("release_state", 32'(bus.state), 32'd1);
      check("release_count", bus.instr_count, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control FSM that sequences fetch, decode, execute, memory and write-back for the MIPS subset. It is the driving side of the PC register's control interface: it produces `PCWrite`, `PCWriteCond` and `PCSource`, which the PC register consumes together with the ALU `zero` flag. It also drives every other datapath strobe: memory, IR, register file and ALU muxes. Memory accesses use a ready handshake, so variable-latency memory is tolerated.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `opcode`  in  6  `IR[31:26]`, valid from DECODE onward.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `PCWrite`  out  1  unconditional PC update.
- `PCWriteCond`  out  1  PC update if `zero` (the PC register gives it priority).
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `IorD`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`  out  1 each  strobes.
- `RegDst`  out  1  0 = rt, 1 = rd.
- `MemtoReg`  out  1  0 = ALUOut, 1 = MDR.
- `ALUSrcA`  out  1  0 = PC, 1 = A.
- `ALUSrcB`  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- `state`  out  4  current state (debug).
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `instr_count`  out  32  count of completed fetches.

## Operation
State encoding:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11.
- Codes 12–15 are unreachable. If ever entered, the next state is FETCH.

Per-state behaviour. Any strobe not listed for a state is 0; any mux select not listed is 0.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0. Go to DECODE when it is 1.
  - `instr_count` increments (wrapping modulo 2^32) on each FETCH cycle with `mem_ready`=1.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 (addi) → ADDIEX.
  - Any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `IorD`=1. Stay while `mem_ready`=0, then go to MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Next: FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Stay while `mem_ready`=0, then go to FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next: RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Next: FETCH.
- BRANCH: `PCWriteCond`=1, `PCSource`=01, `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01. Next: FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10. Next: FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next: ADDIWB.
- ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Next: FETCH.

## Timing
- `state` and `instr_count` are registered. All other outputs decode combinationally from the current `state`, plus `mem_ready` in FETCH.
- Reset: on a rising edge with `rst`=0, `state` becomes FETCH and `instr_count` becomes 0.
- While `rst`=0, every strobe is forced to 0: `PCWrite`, `PCWriteCond`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `illegal_op`. Mux selects read 0.
- Reset mid-instruction (including during a memory wait) abandons the instruction. No write strobe is asserted after reset is sampled.
- Cycles per instruction with zero wait (`mem_ready` held at 1):
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, j: 3.
  - Each memory wait cycle adds 1.
- `PCWrite` is asserted exactly once per fetch, so the PC advances by 4 exactly once regardless of wait length.
- `PCWrite` and `PCWriteCond` are never both 1 in the same cycle.
- `MemRead` and `MemWrite` are never both 1 in the same cycle.
- `mem_ready` is ignored in every state except FETCH, MEMRD and MEMWR.

## Test plan
- Reset: hold `rst`=0 for 3 cycles from a mid-EXEC state → `state`=0, `instr_count`=0, all strobes 0. Release → FETCH drives `MemRead`=1.
- Zero-wait sequence lw, sw, R-type, addi, beq, j with `mem_ready`=1 → state traces:
  - lw: 0,1,2,3,4.
  - sw: 0,1,2,5.
  - R-type: 0,1,6,7.
  - addi: 0,1,10,11.
  - beq: 0,1,8.
  - j: 0,1,9.
  - `instr_count`=6 after the sixth fetch completes.
- Fetch wait: `mem_ready`=0 for 3 cycles, then 1 → FETCH held 4 cycles, `PCWrite` and `IRWrite` high only in the 4th, `instr_count` +1.
- lw with MEMRD wait of 2 cycles → MEMRD lasts 3 cycles with `IorD`=1 throughout, then MEMWB asserts `RegWrite`=1 and `MemtoReg`=1 for 1 cycle.
- Illegal opcode 111111 → `illegal_op` pulses 1 cycle in DECODE, next state FETCH, no `RegWrite` or `MemWrite` asserted.
- Counter wrap: force `instr_count` to 0xFFFFFFFF, complete one fetch → `instr_count`=0x00000000.
